fifo1_wr_arb: RTL and testbench
===============================

# fifo1_wr_arb

Round-robin write-port arbiter for the `fifo1_sram` write side. It shares the single `winc`/`wdata_in` port between NREQ requesters and grants each requester bounded bursts. Flow control follows the FIFO's `wfull`. The block lives entirely in the write-clock domain, between the producer blocks and the FIFO write interface.

## Interface

Parameters:
- DSIZE, 8: data word width; matches the FIFO DSIZE.
- NREQ, 4: number of requesters, 2..16.
- BURST, 4: maximum writes per grant, 1..256.

Ports:
- wclk, in, 1: write clock; the only clock.
- wrst, in, 1: reset; synchronous, active-high.
- req, in, NREQ: per-requester valid; held high while the requester has a word ready.
- wdata_req, in, NREQ*DSIZE: packed requester data; requester i uses bits [i*DSIZE +: DSIZE].
- wfull, in, 1: FIFO full flag, from `fifo1_sram`.
- winc, out, 1: FIFO write enable, to `fifo1_sram`.
- wdata_in, out, DSIZE: FIFO write data, to `fifo1_sram`.
- gnt, out, NREQ: one-hot consume strobe; gnt[i]=1 means requester i's word is written at this edge.
- busy, out, 1: high in BURST state.
- owner, out, $clog2(NREQ): index of the current burst owner; holds the last value in IDLE.

## Operation

- State machine has two states, IDLE and BURST. Registers: state, owner, last (last granted index), cnt (8 bits).
- IDLE:
  - If any req bit is high at the edge, pick the first requester with req=1 searching from last+1 upward, with modulo NREQ wrap-around.
  - Load owner and last with that index, clear cnt, and go to BURST.
  - If no req bit is high, stay in IDLE.
- BURST, write condition: a write occurs when winc=1.
  - winc = (state==BURST) & req[owner] & !wfull & !wrst. This is combinational.
  - wdata_in = wdata_req[owner] when state==BURST, else 0.
  - gnt = one-hot(owner) & {NREQ{winc}}.
- BURST, edge with a write:
  - If cnt==BURST-1, go to IDLE.
  - Otherwise cnt = cnt+1 and stay in BURST.
- BURST, edge with req[owner]=0: go to IDLE (early release). A partial burst still advances the round-robin pointer.
- BURST, edge with wfull=1 and req[owner]=1: stall. State, owner and cnt hold. The owner keeps the port and is not preempted.
- Requester contract:
  - On the edge where gnt[i]=1, the word is consumed.
  - The requester presents the next word, or drops req, before the following edge.
  - Requesters must not change wdata_req while req is high and gnt is low.
- Fairness: with all requesters saturated, the grant order is 0,1,…,NREQ-1,0,… with BURST words each.
- Reset: see Timing for the values applied on the reset edge.

## Timing

- Arbitration costs exactly one IDLE cycle between bursts, with winc=0 in that cycle. Maximum throughput is BURST/(BURST+1) words per cycle.
- Latency:
  - req rising in IDLE leads to the first winc in the next cycle (one edge later).
  - Once in BURST, winc and gnt respond combinationally to req[owner] and wfull in the same cycle.
- wfull is sampled combinationally, not registered. The FIFO's registered wfull asserts after the write that fills it, so no write ever happens while wfull=1: zero overflow.
- Simultaneous events:
  - A write on the BURST-1 count together with req dropping: the write completes, then the block goes to IDLE.
  - wfull deasserting while a stall is in progress resumes writing in that same cycle.
- Reset:
  - On any edge with wrst=1: state=IDLE, last=NREQ-1 so that requester 0 wins first, owner=0, cnt=0.
  - While wrst=1: winc=0, gnt=0, wdata_in=0, busy=0, owner=0 combinationally.
  - Reset in the middle of a burst aborts it with no partial write.
- cnt is 8 bits and is compared against BURST-1, so BURST=256 wraps correctly and cnt never exceeds BURST-1.

## Test plan

- Single requester, BURST=4: req[0] held for 6 words with data 0x10..0x15. Required:
  - winc pattern is 0,1,1,1,1,0,1,1.
  - gnt[0] is high on each winc.
  - FIFO rdata reads back 0x10..0x15 in order.
- Contention, all 4 requesters saturated, each with data {id,count}. Required:
  - Grant owner sequence 0,1,2,3,0 with 4 words each.
  - Exactly one gnt bit high per write cycle.
  - busy is low for exactly one cycle between bursts.
- Full stall, BURST=4: fill the FIFO to 2**ASIZE-1 entries, then requester 2 offers 3 words. Required:
  - 1 word is written, then wfull=1 forces winc=0 for the whole stall.
  - owner=2 and cnt hold.
  - After one read, the remaining 2 words are written with no loss or duplication.
- Early release: req[1] drops after 2 of 4 words while req[3] is pending. Required: the block goes to IDLE and the next owner is 3, not 1.
- Reset mid-burst: wrst=1 for one edge during requester 1's second word. Required:
  - winc=0 in the reset cycle and owner=0 afterwards.
  - The next grant goes to requester 0 if req[0]=1.
  - FIFO contents contain no word from the aborted cycle.

Source files
------------

// File: rtl/fifo1_wr_arb.sv
// Round-robin arbiter sharing the fifo1_sram write port among NREQ requesters.
// Each grant is a burst of up to BURST words, throttled combinationally by wfull.
module fifo1_wr_arb #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned BURST = 4,
    localparam int unsigned OW   = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] wdata_req,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [OW-1:0]         owner
);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [OW-1:0] pick;
    logic [31:0]   idx;
    logic          found;
    logic          own_req;
    logic          in_burst;

    // First requesting index after the last grant, wrapping modulo NREQ.
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && req[idx[OW-1:0]]) begin
                pick  = idx[OW-1:0];
                found = 1'b1;
            end
        end
    end

    assign own_req  = req[owner_q];
    assign in_burst = (state_q == StBurst) && !wrst;
    assign winc     = in_burst && own_req && !wfull;
    assign wdata_in = in_burst ? wdata_req[32'(owner_q) * DSIZE +: DSIZE] : '0;
    assign gnt      = winc ? (NREQ'(1) << owner_q) : '0;
    assign busy     = in_burst;
    assign owner    = wrst ? '0 : owner_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBurst;
                    owner_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            StBurst: begin
                if (!own_req) begin
                    state_d = StIdle;
                end else if (!wfull) begin
                    if (cnt_q == 8'(BURST - 1)) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // last resets to NREQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo1_wr_arb.sv
// Bench for fifo1_wr_arb: directed scenarios plus random traffic, checked every cycle
// against a burst-level arbiter model feeding a queue-based FIFO model.
module tb_fifo1_wr_arb;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int DEPTH = 8;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] wdata_req;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata_in;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [1:0]            owner;

    fifo1_wr_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req       (req),
        .wdata_req (wdata_req),
        .wfull     (wfull),
        .winc      (winc),
        .wdata_in  (wdata_in),
        .gnt       (gnt),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 wclk = ~wclk;

    int         nasserts = 0;
    int         nfail    = 0;
    int         left[NREQ];
    logic [7:0] dat[NREQ];
    logic [7:0] fifo[$];
    logic [7:0] wlog[$];
    int         own_seq[$];
    bit         drain;
    bit         m_busy;
    int         m_own, m_last, m_n;
    logic       last_winc;
    int         last_owner;
    logic [7:0] pat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nasserts++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst);
        logic            e_winc;
        logic [NREQ-1:0] e_gnt;
        logic [7:0]      e_data;
        logic            a_winc;
        logic [7:0]      a_data;
        bit              fnd;
        int              idx;
        wrst = rst;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (left[i] > 0);
            wdata_req[i*DSIZE +: DSIZE] = dat[i];
        end
        wfull = (fifo.size() >= DEPTH);
        @(negedge wclk);
        e_winc = m_busy && req[m_own] && !wfull && !rst;
        e_gnt  = e_winc ? (NREQ'(1) << m_own) : '0;
        e_data = (m_busy && !rst) ? dat[m_own] : 8'h00;
        chk("winc", 32'(winc), 32'(e_winc));
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("wdata_in", 32'(wdata_in), 32'(e_data));
        chk("busy", 32'(busy), 32'(m_busy && !rst));
        chk("owner", 32'(owner), rst ? 32'd0 : 32'(m_own));
        a_winc     = winc;
        a_data     = wdata_in;
        last_winc  = winc;
        last_owner = int'(owner);
        @(posedge wclk);
        #1;
        if (a_winc) begin
            fifo.push_back(a_data);
            wlog.push_back(a_data);
            own_seq.push_back(last_owner);
        end
        if (drain && fifo.size() > 0) void'(fifo.pop_front());
        if (e_winc) begin
            left[m_own]--;
            dat[m_own]++;
        end
        // Burst-level model: idle picks round-robin, a burst ends after BURST words or on release.
        if (rst) begin
            m_busy = 1'b0;
            m_last = NREQ - 1;
            m_own  = 0;
            m_n    = 0;
        end else if (!m_busy) begin
            fnd = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (m_last + k) % NREQ;
                if (!fnd && req[idx]) begin
                    fnd    = 1'b1;
                    m_own  = idx;
                    m_last = idx;
                    m_n    = 0;
                    m_busy = 1'b1;
                end
            end
        end else if (!req[m_own]) begin
            m_busy = 1'b0;
        end else if (!wfull) begin
            m_n++;
            if (m_n == BURST) m_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            dat[i]  = 8'h00;
        end
        drain = 1'b0;
        step(1'b1);
        fifo.delete();
        wlog.delete();
        own_seq.delete();
    endtask

    initial begin
        m_busy = 1'b0;
        m_own  = 0;
        m_last = NREQ - 1;
        m_n    = 0;
        do_reset();
        do_reset();

        // Single requester: 6 words through a BURST=4 arbiter.
        dat[0]  = 8'h10;
        left[0] = 6;
        pat     = '0;
        for (int s = 0; s < 8; s++) begin
            step(1'b0);
            pat = {pat[6:0], last_winc};
        end
        chk("single_pattern", 32'(pat), 32'(8'b0111_1011));
        chk("single_count", fifo.size(), 6);
        for (int j = 0; j < 6; j++) begin
            chk("single_rdata", 32'(fifo[j]), 32'h10 + j);
        end

        // All requesters saturated: fair order 0,1,2,3,0 with BURST words each.
        do_reset();
        drain = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            dat[i]  = 8'(i << 4);
            left[i] = 1000;
        end
        for (int s = 0; s < 25; s++) step(1'b0);
        chk("rr_writes", own_seq.size(), 20);
        for (int j = 0; j < 20 && j < own_seq.size(); j++) begin
            chk("rr_owner_seq", own_seq[j], (j / BURST) % NREQ);
        end

        // Full stall: FIFO one short of full, requester 2 offers 3 words.
        do_reset();
        for (int j = 0; j < DEPTH - 1; j++) fifo.push_back(8'hEE);
        dat[2]  = 8'hA0;
        left[2] = 3;
        step(1'b0);
        step(1'b0);
        chk("stall_first_write", wlog.size(), 1);
        for (int s = 0; s < 3; s++) begin
            step(1'b0);
            chk("stall_winc", 32'(last_winc), 0);
            chk("stall_owner", last_owner, 2);
        end
        drain = 1'b1;
        for (int s = 0; s < 6; s++) step(1'b0);
        chk("stall_total", wlog.size(), 3);
        for (int j = 0; j < 3 && j < wlog.size(); j++) begin
            chk("stall_data", 32'(wlog[j]), 32'hA0 + j);
        end

        // Early release: requester 1 drops after 2 words, requester 3 is waiting.
        do_reset();
        drain   = 1'b1;
        dat[1]  = 8'h50;
        dat[3]  = 8'h70;
        left[1] = 2;
        left[3] = 5;
        for (int s = 0; s < 4; s++) step(1'b0);
        chk("release_idle", 32'(busy), 0);
        left[1] = 4;
        step(1'b0);
        step(1'b0);
        chk("release_owner", last_owner, 3);
        chk("release_winc", 32'(last_winc), 1);

        // Reset in the middle of requester 1's burst.
        do_reset();
        drain   = 1'b1;
        dat[1]  = 8'hB0;
        left[1] = 4;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        chk("rst_winc", 32'(last_winc), 0);
        chk("rst_owner", last_owner, 0);
        dat[0]  = 8'hC0;
        left[0] = 3;
        step(1'b0);
        step(1'b0);
        chk("rst_next_owner", last_owner, 0);
        chk("rst_log_size", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("rst_log0", 32'(wlog[0]), 32'hB0);
            chk("rst_log1", 32'(wlog[1]), 32'hC0);
        end

        // Random traffic with random draining and occasional resets.
        do_reset();
        for (int s = 0; s < 400; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (left[i] == 0 && $urandom_range(0, 3) == 0) left[i] = $urandom_range(1, 6);
            end
            drain = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
        $finish;
    end

endmodule
